// File: rtl/la_debounce.sv
// Clocked glitch filter for a single-bit level: a change is accepted only after it
// persists for cfg_cnt+1 consecutive enabled cycles; emits registered rise/fall pulses.
module la_debounce #(
  parameter              PROP   = "DEFAULT",
  parameter int unsigned CW     = 8,
  parameter bit          INVERT = 1'b1,
  parameter bit          SYNC   = 1'b0,
  parameter bit          RSTVAL = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          din,
  input  logic [CW-1:0] cfg_cnt,
  output logic          dout,
  output logic          rise,
  output logic          fall,
  output logic          busy
);

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s;
  logic          smp;

  assign s = INVERT ? ~din : din;

  generate
    if (SYNC) begin : g_sync
      // Synchronizer stages hold with en low so a frozen filter sees no hidden progress.
      logic [1:0] sff;
      always_ff @(posedge clk) begin
        if (reset) begin
          sff <= {2{RSTVAL}};
        end else if (en) begin
          sff <= {sff[0], s};
        end
      end
      assign smp = sff[1];
    end else begin : g_nosync
      assign smp = s;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE;
      cnt   <= '0;
      dout  <= RSTVAL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        case (state)
          STABLE: begin
            if (smp != dout) begin
              if (cfg_cnt == '0) begin
                dout <= smp;
                rise <= smp;
                fall <= ~smp;
              end else begin
                state <= CHECK;
                cnt   <= CNT_ONE;
                busy  <= 1'b1;
              end
            end else begin
              cnt <= '0;
            end
          end
          CHECK: begin
            if (smp == dout) begin
              state <= STABLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else if (cnt >= cfg_cnt) begin
              // >= lets a live reduction of cfg_cnt accept immediately; cnt never wraps.
              dout  <= smp;
              rise  <= smp;
              fall  <= ~smp;
              state <= STABLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            state <= STABLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_la_debounce.sv
// Self-checking bench for la_debounce: table-driven vectors plus hand sequences,
// with expected {dout,rise,fall,busy} queued at drive time and compared after the edge.
module tb_la_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       din;
  logic [7:0] cfg;

  logic dout_a, rise_a, fall_a, busy_a;
  logic dout_b, rise_b, fall_b, busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         rst;
    bit         en;
    logic       din;
    logic [7:0] cfg;
    logic [3:0] exp;
    string      nm;
  } vec_t;

  typedef struct {
    int         sel;
    logic [3:0] exp;
    string      nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  la_debounce #(.PROP("DEFAULT"), .CW(8), .INVERT(1'b1), .SYNC(1'b0), .RSTVAL(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_cnt(cfg),
    .dout(dout_a), .rise(rise_a), .fall(fall_a), .busy(busy_a)
  );

  la_debounce #(.PROP("DEFAULT"), .CW(8), .INVERT(1'b0), .SYNC(1'b1), .RSTVAL(1'b0)) u_b (
    .clk(clk), .reset(reset), .en(en), .din(din), .cfg_cnt(cfg),
    .dout(dout_b), .rise(rise_b), .fall(fall_b), .busy(busy_b)
  );

  function automatic void add(input bit r, input bit e, input logic d, input logic [7:0] c,
                              input logic [3:0] ex, input string nm);
    tbl.push_back('{r, e, d, c, ex, nm});
  endfunction

  task automatic check_out();
    sb_t        t;
    logic [3:0] act;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty act=none req=entry");
      return;
    end
    t   = sbq.pop_front();
    act = (t.sel == 0) ? {dout_a, rise_a, fall_a, busy_a} : {dout_b, rise_b, fall_b, busy_b};
    checks++;
    if (act !== t.exp || (act[2] && act[1])) begin
      errors++;
      $display("FAIL %s dut=%0d {dout,rise,fall,busy} act=%b req=%b", t.nm, t.sel, act, t.exp);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic d, input logic [7:0] c,
                      input int sel, input logic [3:0] ex, input string nm);
    reset = r;
    en    = e;
    din   = d;
    cfg   = c;
    sbq.push_back('{sel, ex, nm});
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset hold, din toggling (and X) with reset high; en low must not matter
    add(1, 1, 1'b0, 8'd3, 4'b0000, "reset_hold");
    add(1, 0, 1'b1, 8'd3, 4'b0000, "reset_hold");
    add(1, 1, 1'bx, 8'd3, 4'b0000, "reset_hold_x");
    add(0, 1, 1'b1, 8'd3, 4'b0000, "post_release");
    // Clean transition, cfg_cnt=3
    for (int i = 0; i < 3; i++) add(0, 1, 1'b0, 8'd3, 4'b0001, "clean_busy");
    add(0, 1, 1'b0, 8'd3, 4'b1100, "clean_rise");
    add(0, 1, 1'b0, 8'd3, 4'b1000, "clean_hold");
    // Return to dout=0 via zero threshold
    add(0, 1, 1'b1, 8'd0, 4'b0010, "back_fall");
    add(0, 1, 1'b1, 8'd0, 4'b0000, "back_hold");
    // Glitches of length 3 and 4 rejected at cfg_cnt=4, length 5 accepted
    for (int i = 0; i < 3; i++) add(0, 1, 1'b0, 8'd4, 4'b0001, "glitch3_busy");
    add(0, 1, 1'b1, 8'd4, 4'b0000, "glitch3_reject");
    for (int i = 0; i < 4; i++) add(0, 1, 1'b0, 8'd4, 4'b0001, "glitch4_busy");
    add(0, 1, 1'b1, 8'd4, 4'b0000, "glitch4_reject");
    for (int i = 0; i < 4; i++) add(0, 1, 1'b0, 8'd4, 4'b0001, "glitch5_busy");
    add(0, 1, 1'b0, 8'd4, 4'b1100, "glitch5_accept");
    add(0, 1, 1'b1, 8'd4, 4'b1001, "bounce_start");
    add(0, 1, 1'b0, 8'd4, 4'b1000, "bounce_reject");
    // Zero threshold, din toggling every 2 cycles
    add(0, 1, 1'b1, 8'd0, 4'b0010, "zero_fall");
    add(0, 1, 1'b1, 8'd0, 4'b0000, "zero_hold");
    add(0, 1, 1'b0, 8'd0, 4'b1100, "zero_rise");
    add(0, 1, 1'b0, 8'd0, 4'b1000, "zero_hold");
    add(0, 1, 1'b1, 8'd0, 4'b0010, "zero_fall2");
    add(0, 1, 1'b1, 8'd0, 4'b0000, "zero_hold2");
    // Enable freeze mid-CHECK at cfg_cnt=5: 6 enabled differing cycles in total
    for (int i = 0; i < 2; i++) add(0, 1, 1'b0, 8'd5, 4'b0001, "en_busy_pre");
    for (int i = 0; i < 10; i++) add(0, 0, (i % 2 == 0) ? 1'b1 : 1'b0, 8'd5, 4'b0001, "en_frozen");
    for (int i = 0; i < 3; i++) add(0, 1, 1'b0, 8'd5, 4'b0001, "en_busy_post");
    add(0, 1, 1'b0, 8'd5, 4'b1100, "en_accept");
    add(0, 0, 1'b1, 8'd5, 4'b1000, "en_pulse_drop");
    // Reset mid-CHECK aborts without a pulse
    add(0, 1, 1'b1, 8'd5, 4'b1001, "rstmid_busy");
    add(0, 1, 1'b1, 8'd5, 4'b1001, "rstmid_busy");
    add(1, 1, 1'b1, 8'd5, 4'b0000, "rstmid_reset");
    add(0, 1, 1'b1, 8'd5, 4'b0000, "rstmid_after");

    foreach (tbl[k]) step(tbl[k].rst, tbl[k].en, tbl[k].din, tbl[k].cfg, 0, tbl[k].exp, tbl[k].nm);

    // All-ones threshold needs 2^CW consecutive differing cycles
    step(1, 1, 1'b1, 8'd255, 0, 4'b0000, "ones_reset");
    for (int i = 0; i < 255; i++) step(0, 1, 1'b0, 8'd255, 0, 4'b0001, "ones_busy");
    step(0, 1, 1'b0, 8'd255, 0, 4'b1100, "ones_accept");

    // Synchronized, non-inverting instance
    step(1, 1, 1'b0, 8'd2, 1, 4'b0000, "sync_reset");
    step(1, 1, 1'b0, 8'd2, 1, 4'b0000, "sync_reset");
    step(0, 1, 1'b1, 8'd2, 1, 4'b0000, "sync_stage1");
    step(0, 1, 1'b1, 8'd2, 1, 4'b0000, "sync_stage2");
    step(0, 1, 1'b1, 8'd2, 1, 4'b0001, "sync_busy");
    step(0, 1, 1'b1, 8'd2, 1, 4'b0001, "sync_busy");
    step(0, 1, 1'b1, 8'd2, 1, 4'b1100, "sync_rise");
    step(0, 1, 1'b1, 8'd2, 1, 4'b1000, "sync_hold");
    // Live lowering of cfg_cnt from 7 to 1 while cnt=3
    step(0, 1, 1'b0, 8'd7, 1, 4'b1000, "lower_stage1");
    step(0, 1, 1'b0, 8'd7, 1, 4'b1000, "lower_stage2");
    step(0, 1, 1'b0, 8'd7, 1, 4'b1001, "lower_cnt1");
    step(0, 1, 1'b0, 8'd7, 1, 4'b1001, "lower_cnt2");
    step(0, 1, 1'b0, 8'd7, 1, 4'b1001, "lower_cnt3");
    step(0, 1, 1'b0, 8'd1, 1, 4'b0010, "lower_accept");
    step(0, 1, 1'b0, 8'd1, 1, 4'b0000, "lower_hold");

    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover act=%0d req=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
